// File: rtl/gat_loader_pkg.sv
// Shared types and constants for the GAT input-BRAM loader.
// State encodings are plain 2-bit constants so legacy netlists can compare them directly.
package gat_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Word index to byte address shift; the top-level wrapper strips the same two bits.
  localparam int BYTE_ADDR_LSB = 2;
  localparam int CHECKSUM_W    = 32;

endpackage

// File: rtl/gat_load_checksum.sv
// Running mod-2^32 sum of accepted stream words; built only when the loader is
// compiled with GAT_LOADER_CHECKSUM_EN.
module gat_load_checksum
  import gat_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  add_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CHECKSUM_W-1:0] sum_o
);

  logic [CHECKSUM_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_q + CHECKSUM_W'(data_i);
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/gat_bram_loader.sv
// Stream-to-BRAM loader for the GAT input BRAMs: one registered write per accepted beat,
// load_done once DEPTH words are committed. Optional checksum: GAT_LOADER_CHECKSUM_EN.
module gat_bram_loader
  import gat_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 19,
  parameter int DEPTH      = 242101,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            s_valid,
  input  logic                            s_last,
  output logic                            s_ready,
  output logic [DATA_WIDTH-1:0]           bram_din,
  output logic                            bram_ena,
  output logic                            bram_wea,
  output logic [ADDR_W+BYTE_ADDR_LSB-1:0] bram_addra,
  output logic                            load_done,
  output logic                            busy,
  output logic                            err_len,
  output logic [ADDR_W:0]                 word_count,
  output logic [CHECKSUM_W-1:0]           checksum
);

  typedef logic [ADDR_W:0] count_t;
  localparam count_t LAST_IDX = count_t'(DEPTH - 1);

  state_t                          state_q, state_d;
  count_t                          count_q, count_d;
  logic                            wr_q, wr_d;
  logic [DATA_WIDTH-1:0]           din_q, din_d;
  logic [ADDR_W+BYTE_ADDR_LSB-1:0] addr_q, addr_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;

  logic accept;
  logic arm;
  logic last_idx;

  assign s_ready  = (state_q == ST_LOAD);
  assign accept   = s_valid && s_ready;
  assign arm      = start && (state_q != ST_LOAD);
  assign last_idx = (count_q == LAST_IDX);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    count_d = count_q;
    wr_d    = 1'b0;
    din_d   = din_q;
    addr_d  = addr_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d = ST_LOAD;
          count_d = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
        end else if (state_q == ST_DONE) begin
          // Lags DONE entry by one cycle so the final write is committed first.
          done_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_d    = 1'b1;
          din_d   = s_data;
          addr_d  = {count_q[ADDR_W-1:0], {BYTE_ADDR_LSB{1'b0}}};
          count_d = count_q + count_t'(1);
          if (last_idx || s_last) begin
            state_d = ST_DONE;
            // A mismatch either way (early s_last or missing s_last) flags the length error.
            err_d   = last_idx ^ s_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bram_din   = din_q;
  assign bram_ena   = wr_q;
  assign bram_wea   = wr_q;
  assign bram_addra = addr_q;
  assign load_done  = done_q;
  assign busy       = (state_q == ST_LOAD);
  assign err_len    = err_q;
  assign word_count = count_q;

`ifdef GAT_LOADER_CHECKSUM_EN
  gat_load_checksum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_checksum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (arm),
    .add_en_i (accept),
    .data_i   (s_data),
    .sum_o    (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_gat_bram_loader.sv
// Scoreboarded bench for gat_bram_loader at DEPTH=8: expected writes are queued as beats
// are accepted and popped by a write monitor on the falling edge.
module tb_gat_bram_loader;

  localparam int DW    = 19;
  localparam int DEPTH = 8;
  localparam int AW    = 5;
  localparam int CW    = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [DW-1:0] bram_din;
  logic          bram_ena;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic          load_done;
  logic          busy;
  logic          err_len;
  logic [CW-1:0] word_count;
  logic [31:0]   checksum;

  int          checks = 0;
  int          failures = 0;
  int          exp_idx = 0;
  logic [31:0] exp_sum = '0;
  wr_t         exp_q[$];
  wr_t         mon_w;

  gat_bram_loader #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .bram_din   (bram_din),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .load_done  (load_done),
    .busy       (busy),
    .err_len    (err_len),
    .word_count (word_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_checksum();
`ifdef GAT_LOADER_CHECKSUM_EN
    return exp_sum;
`else
    return 32'd0;
`endif
  endfunction

  // Write monitor: every strobe must match the oldest queued expected write.
  always @(negedge clk) begin
    checks++;
    if (bram_wea !== bram_ena) begin
      failures++;
      $display("FAIL wea_vs_ena: wea=%b ena=%b", bram_wea, bram_ena);
    end
    if (bram_ena === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr=%0h din=%0h", bram_addra, bram_din);
      end else begin
        mon_w = exp_q.pop_front();
        if (bram_addra !== mon_w.addr || bram_din !== mon_w.din) begin
          failures++;
          $display("FAIL bram_write: addr=%0h din=%0h expected addr=%0h din=%0h",
                   bram_addra, bram_din, mon_w.addr, mon_w.din);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    exp_idx = 0;
    exp_sum = '0;
    checks++;
    if (busy !== 1'b1 || word_count !== '0 || load_done !== 1'b0 || err_len !== 1'b0) begin
      failures++;
      $display("FAIL start_arm: busy=%b count=%0d done=%b err=%b expected 1 0 0 0",
               busy, word_count, load_done, err_len);
    end
  endtask

  // Offers one beat, queues the expected write once it is accepted, then idles `gap` cycles.
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input int gap);
    int waited = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    @(negedge clk);
    while (s_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL beat_accept: s_ready=%b expected 1 for data=%0h", s_ready, d);
      s_valid = 1'b0;
      return;
    end
    exp_q.push_back('{addr: AW'(exp_idx * 4), din: d});
    exp_idx++;
    exp_sum += 32'(d);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 'x;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      checks++;
      if (bram_ena !== 1'b0) begin
        failures++;
        $display("FAIL idle_strobe: ena=%b expected 0", bram_ena);
      end
    end
  endtask

  // Called right after the final beat's write becomes visible.
  task automatic check_done(input logic exp_err, input int exp_cnt);
    checks++;
    if (load_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_early: load_done=%b busy=%b expected 0 0", load_done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (load_done !== 1'b1) begin
      failures++;
      $display("FAIL done_rise: load_done=%b expected 1", load_done);
    end
    checks++;
    if (err_len !== exp_err) begin
      failures++;
      $display("FAIL err_len: got %b expected %b", err_len, exp_err);
    end
    checks++;
    if (word_count !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL word_count: got %0d expected %0d", word_count, exp_cnt);
    end
    checks++;
    if (checksum !== exp_checksum()) begin
      failures++;
      $display("FAIL checksum: got %0h expected %0h", checksum, exp_checksum());
    end
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_state: s_ready=%b busy=%b expected 0 0", s_ready, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes: %0d expected writes never seen", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bram_ena, bram_wea, bram_din, bram_addra, load_done, busy, err_len,
         word_count, checksum, s_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ena=%b din=%0h addr=%0h done=%b busy=%b err=%b cnt=%0d sum=%0h rdy=%b expected all 0",
               bram_ena, bram_din, bram_addra, load_done, busy, err_len, word_count, checksum, s_ready);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b s_ready=%b expected 0 0", busy, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    for (int i = 1; i <= DEPTH; i++) send_beat(DW'(i), i == DEPTH, 0);
    check_done(1'b0, DEPTH);
  endtask

  task automatic test_throttled();
    do_start();
    for (int i = 1; i <= DEPTH; i++) send_beat(DW'(i), i == DEPTH, (i == DEPTH) ? 0 : 1);
    check_done(1'b0, DEPTH);
  endtask

  task automatic test_short_load();
    do_start();
    for (int i = 1; i <= 5; i++) send_beat(DW'(i), i == 5, 0);
    check_done(1'b1, 5);
  endtask

  task automatic test_missing_last();
    do_start();
    for (int i = 1; i <= DEPTH; i++) send_beat(DW'(i + 40), 1'b0, 0);
    s_data  = DW'(99);
    s_valid = 1'b1;
    check_done(1'b1, DEPTH);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (s_ready !== 1'b0 || word_count !== CW'(DEPTH)) begin
        failures++;
        $display("FAIL ninth_beat: s_ready=%b count=%0d expected 0 %0d", s_ready, word_count, DEPTH);
      end
    end
    s_valid = 1'b0;
    s_data  = 'x;
  endtask

  task automatic test_reset_mid_load();
    do_start();
    for (int i = 1; i <= 3; i++) send_beat(DW'(i), 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bram_ena, bram_wea, bram_din, bram_addra, load_done, busy, err_len,
         word_count, checksum, s_ready} !== '0) begin
      failures++;
      $display("FAIL midload_reset: ena=%b din=%0h addr=%0h done=%b busy=%b err=%b cnt=%0d sum=%0h rdy=%b expected all 0",
               bram_ena, bram_din, bram_addra, load_done, busy, err_len, word_count, checksum, s_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL midload_idle: busy=%b load_done=%b expected 0 0", busy, load_done);
    end
    do_start();
    for (int i = 1; i <= DEPTH; i++) send_beat(DW'(i + 16), i == DEPTH, 0);
    check_done(1'b0, DEPTH);
  endtask

  task automatic test_rearm();
    do_start();
    send_beat(DW'(1), 1'b0, 0);
    start = 1'b1;
    send_beat(DW'(2), 1'b0, 0);
    start = 1'b0;
    checks++;
    if (word_count !== CW'(2) || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_in_load: count=%0d busy=%b expected 2 1", word_count, busy);
    end
    for (int i = 3; i <= DEPTH; i++) send_beat(DW'(i), i == DEPTH, 0);
    check_done(1'b0, DEPTH);
    @(posedge clk); #1;
    checks++;
    if (load_done !== 1'b1) begin
      failures++;
      $display("FAIL done_hold: load_done=%b expected 1", load_done);
    end
    do_start();
    for (int i = 1; i <= DEPTH; i++) send_beat(DW'(19'h7FFFF), i == DEPTH, 0);
    check_done(1'b0, DEPTH);
`ifdef GAT_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h003F_FFF8) begin
      failures++;
      $display("FAIL checksum_max: got %0h expected 3ffff8", checksum);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_throttled();
    test_short_load();
    test_missing_last();
    test_reset_mid_load();
    test_rearm();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
